// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result handshake bundle for seq_mult.
//   in_valid/in_ready   operand handshake; in_a, in_b, in_signed ride with it
//   out_valid/out_ready result handshake; out_product rides with it
// master: producer of operands and consumer of results.
// slave : the multiplier.
interface seq_mult_if #(
  parameter int WIDTH = 10
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits,
// unsigned or two's-complement signed per operation (in_signed).
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_mult_if slave: operand handshake in, result handshake out
// One partial product is retired per cycle; latency is WIDTH cycles from
// accept to out_valid, and one operation is in flight at a time.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | retiring partial products, one per cycle
// DONE  | result held on out_product, out_valid=1 until taken
module seq_mult #(
  parameter int WIDTH = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_mult_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    a_sh;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] b_sh;
  logic             sgn;
  logic [CW-1:0]    cnt;
  logic             last_step;
  logic             in_ready_i;
  logic             out_valid_i;
  logic             accept;

  assign last_step = (cnt == CW'(WIDTH - 1));
  assign accept    = bus.in_valid && in_ready_i;

  // a_sh already holds (extended a << i) at step i and b_sh[0] is bit i of b.
  // In signed mode the MSB of b weighs -2^(WIDTH-1), hence the subtract.
  always_comb begin
    acc_nxt = acc;
    if (b_sh[0]) begin
      if (last_step && sgn) acc_nxt = acc - a_sh;
      else                  acc_nxt = acc + a_sh;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_i  = 1'b0;
    out_valid_i = 1'b0;
    case (state)
      IDLE: begin
        in_ready_i = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid_i = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      sgn  <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
      prod <= '0;
    end else if (accept) begin
      a_sh <= bus.in_signed ? {{WIDTH{bus.in_a[WIDTH-1]}}, bus.in_a}
                            : {{WIDTH{1'b0}}, bus.in_a};
      b_sh <= bus.in_b;
      sgn  <= bus.in_signed;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      if (last_step) prod <= acc_nxt;
      else           cnt  <= cnt + 1'b1;
    end
  end

  assign bus.in_ready    = in_ready_i;
  assign bus.out_valid   = out_valid_i;
  assign bus.out_product = prod;
endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;
  localparam int W  = 10;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Present operands and wait for the accept edge; returns #1 after it.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
    int guard;
    guard = 0;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges until out_valid is seen; timeout flagged after 100 edges.
  task automatic wait_valid(output int cycles, output bit timeout);
    cycles = 0;
    while (!bus.out_valid && cycles < 100) begin
      @(posedge clk); #1; cycles++;
    end
    timeout = !bus.out_valid;
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic s);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[W-1]) sa = sa - (longint'(1) << W);
    if (s && b[W-1]) sb = sb - (longint'(1) << W);
    return PW'(sa * sb);
  endfunction

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_signed = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_product !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b product=%h, want 1 0 00000",
               bus.in_ready, bus.out_valid, bus.out_product);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One full operation with immediate consumption and latency check.
  task automatic run_simple(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic s,
                            input logic [PW-1:0] want);
    int cyc; bit to;
    bus.out_ready = 1'b1;
    start_op(a, b, s);
    wait_valid(cyc, to);
    checks++;
    if (to || cyc != W) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (timeout=%b), want %0d", name, cyc, to, W);
    end
    checks++;
    if (bus.out_product !== want) begin
      errors++;
      $display("FAIL %s product: got %h, want %h", name, bus.out_product, want);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s transfer: out_valid=%b in_ready=%b, want 0 1",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_unsigned_max();
    run_simple("unsigned_max", 10'h3FF, 10'h3FF, 1'b0, 20'hFF801);
  endtask

  task automatic test_signed();
    run_simple("signed_min", 10'h200, 10'h200, 1'b1, 20'h40000);
    run_simple("signed_neg1", 10'h3FF, 10'h001, 1'b1, 20'hFFFFF);
    run_simple("unsigned_7x6", 10'd7, 10'd6, 1'b0, 20'h0002A);
  endtask

  task automatic test_back_to_back();
    run_simple("b2b_unsigned", 10'h3FF, 10'h3FF, 1'b0, 20'hFF801);
    run_simple("b2b_signed", 10'h3FF, 10'h3FF, 1'b1, 20'h00001);
  endtask

  task automatic test_backpressure();
    int cyc; bit to; int xfers;
    bus.out_ready = 1'b0;
    start_op(10'd7, 10'd6, 1'b0);
    wait_valid(cyc, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL bp_valid: out_valid never rose, want 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_product !== 20'h0002A) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b product=%h, want 1 0 0002a",
                 i, bus.out_valid, bus.in_ready, bus.out_product);
      end
    end
    bus.out_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid && bus.out_ready) xfers++;
      @(posedge clk); #1;
    end
    checks++;
    if (xfers != 1) begin
      errors++;
      $display("FAIL bp_single_transfer: got %0d transfers, want 1", xfers);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    bus.out_ready = 1'b1;
    start_op(10'h3FF, 10'h3FF, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_product !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: in_ready=%b out_valid=%b product=%h, want 1 0 00000",
               bus.in_ready, bus.out_valid, bus.out_product);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (2 * W + 4) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_stale: out_valid high %0d cycles, want 0", seen);
    end
  endtask

  task automatic test_input_toggle();
    int cyc; bit to;
    bus.out_ready = 1'b1;
    start_op(10'd13, 10'h3FD, 1'b1);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      bus.in_a = W'($urandom); bus.in_b = W'($urandom);
      bus.in_signed = 1'($urandom);
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (!bus.out_valid || bus.out_product !== 20'hFFFD9) begin
      errors++;
      $display("FAIL input_toggle: valid=%b product=%h, want 1 fffd9",
               bus.out_valid, bus.out_product);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_sweep();
    logic [W-1:0] a, b; logic s; logic [PW-1:0] want;
    int guard; bit done; bit checked;
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 300; n++) begin
        a = W'($urandom); b = W'($urandom); s = 1'(m);
        if (n == 0) begin a = '0; b = W'($urandom); end
        want = ref_mul(a, b, s);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        bus.out_ready = 1'($urandom);
        start_op(a, b, s);
        done = 0; checked = 0; guard = 0;
        while (!done && guard < 200) begin
          if (bus.out_valid) begin
            checks++;
            if (bus.out_product !== want) begin
              errors++;
              $display("FAIL sweep[%0d/%0d] a=%h b=%h s=%b: got %h, want %h",
                       m, n, a, b, s, bus.out_product, want);
            end
            checked = 1;
            bus.out_ready = 1'($urandom);
            done = bus.out_ready;
          end else begin
            bus.out_ready = 1'($urandom);
          end
          @(posedge clk); #1; guard++;
        end
        if (!checked) begin
          checks++; errors++;
          $display("FAIL sweep_timeout[%0d/%0d]: no result, want one", m, n);
        end
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_input_toggle();
    test_random_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
